// File: rtl/control_decoder_stage.sv
// control_decoder_stage: registered ID/EX control decoder with a valid/ready handshake,
// a sticky halt FSM (RUN -> DRAIN -> HALTED) and store byte-enables sized by XLEN.
// Optional feature macro: ILLEGAL_TRAP_EN. When it is defined, illegal instructions raise a
// sticky illegal_o and drain/halt like ECALL. When it is undefined, they pass as NOPs.
module control_decoder_stage #(
  parameter int XLEN         = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              mem_to_reg_o,
  output logic [XLEN/8-1:0] data_mem_we_o,
  output logic              rd_we_o,
  output logic              alu_src_b_o,
  output logic              branch_o,
  output logic [1:0]        alu_2bit_op_o,
  output logic              rs1_in_use_o,
  output logic              rs2_in_use_o,
  output logic              pc_operand_o,
  output logic              stop_flag_o,
  output logic              illegal_o
);
  localparam int BE_W = XLEN / 8;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT} state_e;

  state_e          state_q;
  logic [7:0]      cnt_q;
  logic            stop_q, valid_q, valid_d, accept;
  logic            mem_to_reg_q, mem_to_reg_d, rd_we_q, rd_we_d, alu_src_b_q, alu_src_b_d;
  logic            branch_q, branch_d, rs1_q, rs1_d, rs2_q, rs2_d, pc_q, pc_d;
  logic [1:0]      alu_op_q, alu_op_d;
  logic [BE_W-1:0] we_q, we_d;
  logic            is_sys, illegal_d, trap_d;

  wire [6:0] opcode = instr_i[6:0];
  wire [2:0] funct3 = instr_i[14:12];
  // Only opcode and funct3 drive the controls. The register fields belong to other logic.
  logic unused_instr;
  assign unused_instr = ^{instr_i[31:15], instr_i[11:7]};

  // Opcode -> control table. SYSTEM and unknown opcodes give all-zero controls.
  always_comb begin
    mem_to_reg_d = 1'b0; we_d = '0; rd_we_d = 1'b0; alu_src_b_d = 1'b0; branch_d = 1'b0;
    alu_op_d = 2'b00; rs1_d = 1'b0; rs2_d = 1'b0; pc_d = 1'b0; is_sys = 1'b0; illegal_d = 1'b0;
    case (opcode)
      7'b0110011: begin rd_we_d = 1'b1; alu_op_d = 2'b10; rs1_d = 1'b1; rs2_d = 1'b1; end
      7'b0010011: begin rd_we_d = 1'b1; alu_src_b_d = 1'b1; alu_op_d = 2'b11; rs1_d = 1'b1; end
      7'b0000011: begin
        mem_to_reg_d = 1'b1; rd_we_d = 1'b1; alu_src_b_d = 1'b1; rs1_d = 1'b1;
      end
      7'b1100011: begin branch_d = 1'b1; alu_op_d = 2'b01; rs1_d = 1'b1; rs2_d = 1'b1; end
      7'b0100011: begin
        alu_src_b_d = 1'b1; rs1_d = 1'b1; rs2_d = 1'b1;
        case (funct3)
          3'b000:  we_d = BE_W'(1);
          3'b001:  we_d = BE_W'(3);
          3'b010:  we_d = BE_W'(15);
          3'b011:  if (XLEN == 64) we_d = '1; else illegal_d = 1'b1;
          default: illegal_d = 1'b1;
        endcase
      end
      7'b1100111: begin
        rd_we_d = 1'b1; branch_d = 1'b1; alu_src_b_d = 1'b1; rs1_d = 1'b1; pc_d = 1'b1;
      end
      7'b1101111: begin rd_we_d = 1'b1; branch_d = 1'b1; alu_src_b_d = 1'b1; end
      7'b0010111: begin rd_we_d = 1'b1; alu_src_b_d = 1'b1; pc_d = 1'b1; end
      7'b0110111: begin rd_we_d = 1'b1; alu_src_b_d = 1'b1; end
      7'b1110011: is_sys = 1'b1;
      default:    illegal_d = 1'b1;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  assign trap_d = is_sys | illegal_d;
`else
  logic unused_illegal;
  assign unused_illegal = illegal_d;
  assign trap_d         = is_sys;
`endif

  // Flush wins over a same-cycle accept. Downstream backpressure also stalls intake.
  assign in_ready_o = (state_q == S_RUN) & (~valid_q | out_ready_i) & ~flush_i;
  assign accept     = in_valid_i & in_ready_o;
  assign valid_d    = accept | (valid_q & ~out_ready_i & ~flush_i);

  // Halt FSM. Drain counts DRAIN_CYCLES further edges before stop is asserted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RUN;
      cnt_q   <= 8'd0;
      stop_q  <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: if (accept && trap_d) begin
          if (DRAIN_CYCLES == 0) begin
            state_q <= S_HALT;
            stop_q  <= 1'b1;
          end else begin
            state_q <= S_DRAIN;
            cnt_q   <= 8'(DRAIN_CYCLES);
          end
        end
        S_DRAIN: begin
          if (cnt_q == 8'd0) begin
            state_q <= S_HALT;
            stop_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_HALT:  stop_q <= 1'b1;
        default: state_q <= S_RUN;
      endcase
    end
  end

  // ID/EX register. Controls load only on accept and hold otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0; mem_to_reg_q <= 1'b0; we_q <= '0; rd_we_q <= 1'b0; alu_src_b_q <= 1'b0;
      branch_q <= 1'b0; alu_op_q <= 2'b00; rs1_q <= 1'b0; rs2_q <= 1'b0; pc_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (accept) begin
        mem_to_reg_q <= mem_to_reg_d; we_q <= we_d; rd_we_q <= rd_we_d;
        alu_src_b_q <= alu_src_b_d; branch_q <= branch_d; alu_op_q <= alu_op_d;
        rs1_q <= rs1_d; rs2_q <= rs2_d; pc_q <= pc_d;
      end
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  // Sticky illegal flag, set alongside the held illegal instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   illegal_q <= 1'b0;
    else if (accept && illegal_d) illegal_q <= 1'b1;
  end
  assign illegal_o = illegal_q;
`else
  assign illegal_o = 1'b0;
`endif

  assign out_valid_o   = valid_q;
  assign mem_to_reg_o  = mem_to_reg_q;
  assign data_mem_we_o = we_q;
  assign rd_we_o       = rd_we_q;
  assign alu_src_b_o   = alu_src_b_q;
  assign branch_o      = branch_q;
  assign alu_2bit_op_o = alu_op_q;
  assign rs1_in_use_o  = rs1_q;
  assign rs2_in_use_o  = rs2_q;
  assign pc_operand_o  = pc_q;
  assign stop_flag_o   = stop_q;
endmodule

// File: tb/tb_control_decoder_stage.sv
// Directed bench for control_decoder_stage: decode table, stores for XLEN 32/64,
// backpressure, flush priority, drain/halt timing, reset mid-drain, illegal opcode.
module tb_control_decoder_stage;
  logic        clk = 1'b0, reset = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        in_valid = 1'b0, in_valid64 = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, m2r, rd_we, srcb, br, rs1, rs2, pcop, stop, ill;
  logic [3:0]  we;
  logic [1:0]  aop;
  logic        in_ready64, out_valid64, m2r64, rd_we64, srcb64, br64, rs164, rs264, pcop64;
  logic        stop64, ill64;
  logic [7:0]  we64;
  logic [1:0]  aop64;
  int          n_assert = 0, n_fail = 0;

  always #5 clk = ~clk;

  control_decoder_stage #(.XLEN(32), .DRAIN_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .instr_i(instr), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .flush_i(flush), .out_valid_o(out_valid), .out_ready_i(out_ready), .mem_to_reg_o(m2r),
    .data_mem_we_o(we), .rd_we_o(rd_we), .alu_src_b_o(srcb), .branch_o(br),
    .alu_2bit_op_o(aop), .rs1_in_use_o(rs1), .rs2_in_use_o(rs2), .pc_operand_o(pcop),
    .stop_flag_o(stop), .illegal_o(ill));

  control_decoder_stage #(.XLEN(64), .DRAIN_CYCLES(4)) dut64 (
    .clk(clk), .reset(reset), .instr_i(instr), .in_valid_i(in_valid64),
    .in_ready_o(in_ready64), .flush_i(1'b0), .out_valid_o(out_valid64),
    .out_ready_i(out_ready), .mem_to_reg_o(m2r64), .data_mem_we_o(we64), .rd_we_o(rd_we64),
    .alu_src_b_o(srcb64), .branch_o(br64), .alu_2bit_op_o(aop64), .rs1_in_use_o(rs164),
    .rs2_in_use_o(rs264), .pc_operand_o(pcop64), .stop_flag_o(stop64), .illegal_o(ill64));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one instruction this edge, then drop valid.
  task automatic send(input logic [31:0] ins);
    instr = ins; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_valid", out_valid, 0); chk("rst_stop", stop, 0); chk("rst_rdwe", rd_we, 0);
    chk("rst_we", we, 0); chk("rst_ill", ill, 0); chk("rst_aop", aop, 0);
    reset = 1'b1; #1;
    chk("rst_ready", in_ready, 1);
    out_ready = 1'b1;
    tick();

    // 1. addi
    send(32'h00A00093);
    chk("addi_valid", out_valid, 1); chk("addi_rdwe", rd_we, 1); chk("addi_srcb", srcb, 1);
    chk("addi_aop", aop, 2'b11); chk("addi_rs1", rs1, 1); chk("addi_rs2", rs2, 0);
    chk("addi_m2r", m2r, 0); chk("addi_br", br, 0); chk("addi_we", we, 0);
    tick();
    chk("addi_drain_valid", out_valid, 0);

    // 2. stores and a few other opcodes
    send(32'h00208023); chk("sb_we", we, 4'h1); chk("sb_rdwe", rd_we, 0); chk("sb_rs2", rs2, 1);
    send(32'h00209023); chk("sh_we", we, 4'h3);
    send(32'h0020A023); chk("sw_we", we, 4'hF); chk("sw_srcb", srcb, 1);
    instr = 32'h0020B023; in_valid64 = 1'b1;
    tick();
    in_valid64 = 1'b0;
    chk("sd64_we", we64, 8'hFF); chk("sd64_valid", out_valid64, 1);
    send(32'h0000A103); chk("lw_m2r", m2r, 1); chk("lw_rdwe", rd_we, 1); chk("lw_we", we, 0);
    send(32'h00208463); chk("beq_br", br, 1); chk("beq_aop", aop, 2'b01);
    chk("beq_rdwe", rd_we, 0);
    send(32'h000080E7); chk("jalr_pc", pcop, 1); chk("jalr_br", br, 1); chk("jalr_rdwe", rd_we, 1);
    tick();

    // 3. backpressure
    out_ready = 1'b0;
    send(32'h002081B3);
    chk("add_valid", out_valid, 1); chk("add_aop", aop, 2'b10); chk("add_rs2", rs2, 1);
    instr = 32'h00A00093; in_valid = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready", in_ready, 0); chk("bp_aop", aop, 2'b10); chk("bp_valid", out_valid, 1);
      tick();
    end
    out_ready = 1'b1; #1;
    chk("bp_release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_next_aop", aop, 2'b11); chk("bp_next_valid", out_valid, 1);

    // 5. flush beats a same-cycle accept
    out_ready = 1'b0;
    flush = 1'b1; instr = 32'h002081B3; in_valid = 1'b1; #1;
    chk("fl_ready", in_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("fl_valid", out_valid, 0); chk("fl_no_accept_aop", aop, 2'b11);

    // 4. ECALL drain and halt
    send(32'h00000073);
    chk("ec_ready", in_ready, 0); chk("ec_stop0", stop, 0); chk("ec_rdwe", rd_we, 0);
    for (int i = 1; i <= 4; i++) begin
      tick(); chk("ec_stop_drain", stop, 0);
    end
    tick();
    chk("ec_stop5", stop, 1); chk("ec_halt_ready", in_ready, 0);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("ec_flush_stop", stop, 1);
    reset = 1'b0; #2;
    chk("ec_rst_stop", stop, 0);
    reset = 1'b1; #1;
    chk("ec_rst_ready", in_ready, 1);
    // reset mid-drain
    send(32'h00000073);
    tick(); tick();
    reset = 1'b0; #2;
    chk("md_stop", stop, 0); chk("md_valid", out_valid, 0);
    reset = 1'b1; #1;
    chk("md_ready", in_ready, 1);
    for (int i = 0; i < 6; i++) tick();
    chk("md_stop_late", stop, 0); chk("md_ready_late", in_ready, 1);

    // 6. unknown opcode
    send(32'h0000007F);
    chk("ill_valid", out_valid, 1); chk("ill_rdwe", rd_we, 0); chk("ill_aop", aop, 0);
`ifdef ILLEGAL_TRAP_EN
    chk("ill_flag", ill, 1); chk("ill_ready", in_ready, 0);
    for (int i = 1; i <= 4; i++) begin
      tick(); chk("ill_stop_drain", stop, 0);
    end
    tick();
    chk("ill_stop", stop, 1); chk("ill_sticky", ill, 1);
`else
    chk("ill_flag", ill, 0);
    for (int i = 0; i < 6; i++) tick();
    chk("ill_nohalt", stop, 0); chk("ill_ready", in_ready, 1); chk("ill_flag_late", ill, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
